platform_mapper: RTL and testbench

Pixel-pipeline stage that sits directly upstream of the platform graphics ROM. For every VGA pixel it decides whether the pixel falls on a platform tile or on a water/fire pool of the scrolling tower. When it does, it drives the ROM `address`/`platform_type`, takes the ROM's registered `rgb` back, and composites it over the incoming background. All VGA timing signals are delayed so that they stay aligned with the composited colour.

---
 rtl/platform_pkg.sv | 44 ++++
 rtl/vga_if.sv | 13 +
 rtl/platform_scroll_ctr.sv | 29 ++
 rtl/platform_mapper.sv | 131 +++++++++++++
 tb/tb_platform_mapper.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/platform_pkg.sv
// platform_pkg: shared types, tile/pool geometry and tower layout for platform_mapper
package platform_pkg;

    typedef enum logic [1:0] {
        PLATFORM = 2'b00,
        WATER    = 2'b01,
        FIRE     = 2'b10
    } platform_type_e;

    typedef enum logic [1:0] {
        POOL_NONE,
        POOL_WATER,
        POOL_FIRE
    } pool_kind_e;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    localparam int TILE_W = 64;
    localparam int TILE_H = 8;
    localparam int POOL_W = 49;
    localparam int POOL_H = 10;
    localparam logic [11:0] TRANSPARENT_RGB = 12'hF0F;

    localparam int MAX_ROWS = 8;
    localparam int X_START [MAX_ROWS] = '{0, 128, 320, 64, 512, 0, 256, 384};
    localparam int N_TILES [MAX_ROWS] = '{16, 6, 8, 4, 6, 10, 8, 5};
    localparam pool_kind_e POOL_KIND [MAX_ROWS] = '{POOL_FIRE, POOL_NONE, POOL_WATER, POOL_NONE,
                                                    POOL_FIRE, POOL_WATER, POOL_NONE, POOL_FIRE};
    localparam int POOL_X [MAX_ROWS] = '{200, 0, 400, 0, 700, 100, 0, 500};

    // Pool kinds map one-to-one onto the ROM image select.
    function automatic platform_type_e pool_type(input pool_kind_e k);
        return (k == POOL_WATER) ? WATER : FIRE;
    endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: VGA pixel stream bundle (counters, syncs, blanking, colour)
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/platform_scroll_ctr.sv
// platform_scroll_ctr: vblnk rising-edge detector and per-frame scroll offset counter
module platform_scroll_ctr #(
    parameter int SCREEN_HEIGHT = 768,
    parameter int SCROLL_STEP   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vblnk,
    input  logic       scroll_en,
    output logic [9:0] scroll_y
);

    logic       vblnk_prev;
    logic [10:0] sum;

    assign sum = {1'b0, scroll_y} + 11'(SCROLL_STEP);

    // Advance only on the frame-start edge so the offset is stable across a frame.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vblnk_prev <= 1'b0;
            scroll_y   <= '0;
        end else begin
            vblnk_prev <= vblnk;
            if (vblnk && !vblnk_prev && scroll_en)
                scroll_y <= (sum >= 11'(SCREEN_HEIGHT)) ? 10'(sum - 11'(SCREEN_HEIGHT)) : sum[9:0];
        end

endmodule

// File: rtl/platform_mapper.sv
// platform_mapper: maps VGA pixels onto scrolling platform tiles/pools, drives the
// platform ROM and composites its colour over the background (3-clock pipeline).
// Optional: PLATFORM_TRANSPARENCY_EN lets TRANSPARENT_RGB ROM pixels show the background.
module platform_mapper
    import platform_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 1024,
    parameter int SCREEN_HEIGHT = 768,
    parameter int N_PLATFORMS   = 8,
    parameter int PITCH         = 96,
    parameter int SCROLL_STEP   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    vga_if.in           in,
    vga_if.out          out,
    input  logic        scroll_en,
    output logic [11:0] address,
    output logic [1:0]  platform_type,
    input  logic [11:0] rom_rgb,
    output logic [9:0]  scroll_y
);

    logic signed [10:0] y_diff;
    logic signed [10:0] y_w;
    int                 yw;
    int                 hc;
    int                 top;
    int                 lx;
    logic               hit;
    logic [11:0]        addr_n;
    platform_type_e     type_n;
    vga_t               in_v;
    vga_t               d1;
    vga_t               d2;
    logic               hit_d1;
    logic               hit_d2;
    logic               use_rom;

    platform_scroll_ctr #(
        .SCREEN_HEIGHT(SCREEN_HEIGHT),
        .SCROLL_STEP  (SCROLL_STEP)
    ) u_scroll (
        .clk      (clk),
        .rst_n    (rst_n),
        .vblnk    (in.vblnk),
        .scroll_en(scroll_en),
        .scroll_y (scroll_y)
    );

    assign in_v = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};

    // Hit test against every row; scanning downwards lets the lowest row index win.
    always_comb begin
        y_diff = $signed(in.vcount) - $signed({1'b0, scroll_y});
        y_w    = y_diff[10] ? y_diff + 11'(SCREEN_HEIGHT) : y_diff;
        yw     = int'(y_w);
        hc     = int'(in.hcount);
        hit    = 1'b0;
        addr_n = '0;
        type_n = PLATFORM;
        top    = 0;
        lx     = 0;
        for (int i = N_PLATFORMS - 1; i >= 0; i--) begin
            top = i * PITCH + PITCH - TILE_H;
            if (POOL_KIND[i] != POOL_NONE && yw >= top - 2 && yw <= top + POOL_H - 3 &&
                hc >= POOL_X[i] && hc < POOL_X[i] + POOL_W) begin
                lx     = hc - POOL_X[i];
                hit    = 1'b1;
                addr_n = 12'((yw - top + 2) * POOL_W + lx);
                type_n = pool_type(POOL_KIND[i]);
            end else if (yw >= top && yw < top + TILE_H &&
                         hc >= X_START[i] && hc < X_START[i] + N_TILES[i] * TILE_W) begin
                lx     = hc - X_START[i];
                hit    = 1'b1;
                addr_n = 12'((yw - top) * TILE_W + (lx & (TILE_W - 1)));
                type_n = PLATFORM;
            end
        end
        if (in.hblnk || in.vblnk || hc >= SCREEN_WIDTH) begin
            hit    = 1'b0;
            addr_n = '0;
            type_n = PLATFORM;
        end
    end

    // Stage 1 issues the ROM request; stage 2 aligns the VGA fields with the ROM data.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            address       <= '0;
            platform_type <= '0;
            hit_d1        <= 1'b0;
            d1            <= '0;
            hit_d2        <= 1'b0;
            d2            <= '0;
        end else begin
            address       <= addr_n;
            platform_type <= type_n;
            hit_d1        <= hit;
            d1            <= in_v;
            hit_d2        <= hit_d1;
            d2            <= d1;
        end

`ifdef PLATFORM_TRANSPARENCY_EN
    assign use_rom = hit_d2 && (rom_rgb != TRANSPARENT_RGB);
`else
    assign use_rom = hit_d2;
`endif

    // Stage 3 registers the composited pixel and the delayed timing signals.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= d2.hcount;
            out.vcount <= d2.vcount;
            out.hsync  <= d2.hsync;
            out.vsync  <= d2.vsync;
            out.hblnk  <= d2.hblnk;
            out.vblnk  <= d2.vblnk;
            out.rgb    <= use_rom ? rom_rgb : d2.rgb;
        end

endmodule

// File: tb/tb_platform_mapper.sv
// tb_platform_mapper: randomized self-checking bench for platform_mapper with a ROM model
module tb_platform_mapper;

    logic        clk;
    logic        rst_n;
    logic        scroll_en;
    logic [11:0] address;
    logic [1:0]  platform_type;
    logic [11:0] rom_rgb;
    logic [9:0]  scroll_y;
    logic [37:0] out_bits;

    vga_if vin();
    vga_if vout();

    platform_mapper dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in           (vin),
        .out          (vout),
        .scroll_en    (scroll_en),
        .address      (address),
        .platform_type(platform_type),
        .rom_rgb      (rom_rgb),
        .scroll_y     (scroll_y)
    );

    int tests = 0;
    int fails = 0;
    int scroll_m = 0;
    bit prev_m = 0;
    logic [37:0] q[$];

    int XS[8] = '{0, 128, 320, 64, 512, 0, 256, 384};
    int NT[8] = '{16, 6, 8, 4, 6, 10, 8, 5};
    int PK[8] = '{2, 0, 1, 0, 2, 1, 0, 2};
    int PX[8] = '{200, 0, 400, 0, 700, 100, 0, 500};

    assign out_bits = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(input logic [1:0] t, input logic [11:0] a);
        return (a[3:0] == 4'd9) ? 12'hF0F : {t, a[9:0]};
    endfunction

    // Platform graphics ROM: registered, one clock after the request.
    always @(posedge clk) rom_rgb <= rom_f(platform_type, address);

    // Reference: {hit, type, addr} from the layout rectangles in world coordinates.
    function automatic logic [14:0] model(input int hc, input int vc, input bit blank, input int scr);
        int yw;
        int top;
        yw = ((vc - scr) % 768 + 768) % 768;
        if (blank) return '0;
        for (int i = 0; i < 8; i++) begin
            top = i * 96 + 88;
            if (PK[i] != 0 && yw >= top - 2 && yw <= top + 7 && hc >= PX[i] && hc < PX[i] + 49)
                return {1'b1, 2'(PK[i]), 12'((yw - top + 2) * 49 + hc - PX[i])};
            if (yw >= top && yw < top + 8 && hc >= XS[i] && hc < XS[i] + NT[i] * 64)
                return {1'b1, 2'b00, 12'((yw - top) * 64 + (hc - XS[i]) % 64)};
        end
        return '0;
    endfunction

    task automatic cycle(input int hc, input int vc, input bit hb, input bit vb, input bit en, input logic [11:0] bg);
        logic [14:0] m;
        logic [11:0] er;
        logic [37:0] e;
        logic hs;
        logic vs;
        hs = 1'($urandom);
        vs = 1'($urandom);
        vin.hcount = 11'(hc);
        vin.vcount = 11'(vc);
        vin.hsync = hs;
        vin.vsync = vs;
        vin.hblnk = hb;
        vin.vblnk = vb;
        vin.rgb = bg;
        scroll_en = en;
        m = model(hc, vc, hb || vb, scroll_m);
        er = bg;
        if (m[14]) begin
            er = rom_f(m[13:12], m[11:0]);
`ifdef PLATFORM_TRANSPARENCY_EN
            if (er == 12'hF0F) er = bg;
`endif
        end
        q.push_back({11'(hc), 11'(vc), hs, vs, hb, vb, er});
        if (vb && !prev_m && en) scroll_m = (scroll_m + 1) % 768;
        prev_m = vb;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if ({platform_type, address} !== m[13:0]) begin
            fails++;
            $display("FAIL rom_req hc=%0d vc=%0d: got type=%0d addr=%0d, expected type=%0d addr=%0d",
                     hc, vc, platform_type, address, m[13:12], m[11:0]);
        end
        tests++;
        if (scroll_y !== 10'(scroll_m)) begin
            fails++;
            $display("FAIL scroll_y: got %0d, expected %0d", scroll_y, scroll_m);
        end
        tests++;
        if (q.size() == 3) begin
            e = q.pop_front();
            if (out_bits !== e) begin
                fails++;
                $display("FAIL out_pipe: got %h, expected %h", out_bits, e);
            end
        end else if (out_bits !== '0) begin
            fails++;
            $display("FAIL out_fill: got %h, expected 0", out_bits);
        end
    endtask

    task automatic idle();
        cycle(1023, 0, 0, 0, 0, 12'($urandom));
    endtask

    task automatic frame(input bit en);
        cycle(1023, 770, 1, 1, en, 12'($urandom));
        cycle(1023, 0, 0, 0, en, 12'($urandom));
    endtask

    task automatic check_scroll(input string name, input logic [9:0] exp);
        tests++;
        if (scroll_y !== exp) begin
            fails++;
            $display("FAIL %s: got scroll_y=%0d, expected %0d", name, scroll_y, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        scroll_en = 1'b0;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.vsync = 0;
        vin.hblnk = 0; vin.vblnk = 0; vin.rgb = '0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_bits, address, platform_type, scroll_y} !== '0) begin
            fails++;
            $display("FAIL reset_async: got out=%h addr=%h type=%h scroll=%h, expected all 0",
                     out_bits, address, platform_type, scroll_y);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({out_bits, address, platform_type, scroll_y} !== '0) begin
            fails++;
            $display("FAIL reset_hold: got out=%h addr=%h type=%h scroll=%h, expected all 0",
                     out_bits, address, platform_type, scroll_y);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_tile_hit();
        cycle(70, 90, 0, 0, 0, 12'h555);
        tests++;
        if (address !== 12'd134 || platform_type !== 2'b00) begin
            fails++;
            $display("FAIL tile_hit: got addr=%0d type=%0d, expected 134/0", address, platform_type);
        end
        idle();
        idle();
        tests++;
        if (vout.rgb !== 12'h086) begin
            fails++;
            $display("FAIL tile_rgb: got %h, expected 086", vout.rgb);
        end
    endtask

    task automatic test_pool_hit();
        cycle(210, 90, 0, 0, 0, 12'h555);
        tests++;
        if (address !== 12'd206 || platform_type !== 2'b10) begin
            fails++;
            $display("FAIL pool_hit: got addr=%0d type=%0d, expected 206/2", address, platform_type);
        end
        idle();
        idle();
        tests++;
        if (vout.rgb !== 12'h8CE) begin
            fails++;
            $display("FAIL pool_rgb: got %h, expected 8CE", vout.rgb);
        end
    endtask

    task automatic test_blanking();
        cycle(70, 90, 1, 0, 0, 12'hABC);
        tests++;
        if (address !== 12'd0 || platform_type !== 2'b00) begin
            fails++;
            $display("FAIL blank_req: got addr=%0d type=%0d, expected 0/0", address, platform_type);
        end
        idle();
        idle();
        tests++;
        if (vout.rgb !== 12'hABC) begin
            fails++;
            $display("FAIL blank_rgb: got %h, expected ABC", vout.rgb);
        end
    endtask

    task automatic test_transparency();
        logic [11:0] exp;
`ifdef PLATFORM_TRANSPARENCY_EN
        exp = 12'h123;
`else
        exp = 12'hF0F;
`endif
        cycle(73, 90, 0, 0, 0, 12'h123);
        idle();
        idle();
        tests++;
        if (vout.rgb !== exp) begin
            fails++;
            $display("FAIL transparency: got %h, expected %h", vout.rgb, exp);
        end
    endtask

    task automatic test_scroll();
        repeat (3) frame(1);
        check_scroll("scroll_3", 10'd3);
        frame(0);
        check_scroll("scroll_hold", 10'd3);
        repeat (3) cycle(1023, 770, 1, 1, 1, 12'($urandom));
        cycle(1023, 0, 0, 0, 1, 12'($urandom));
        check_scroll("scroll_once_per_frame", 10'd4);
        repeat (763) frame(1);
        check_scroll("scroll_767", 10'd767);
        frame(1);
        check_scroll("scroll_wrap", 10'd0);
    endtask

    task automatic test_underflow();
        repeat (150) frame(1);
        check_scroll("scroll_150", 10'd150);
        cycle(400, (762 + 150) % 768, 0, 0, 0, 12'($urandom));
        tests++;
        if (address !== 12'd144 || platform_type !== 2'b00) begin
            fails++;
            $display("FAIL underflow_row7: got addr=%0d type=%0d, expected 144/0", address, platform_type);
        end
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            int hc;
            int vc;
            int r;
            r = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                vc = (r * 96 + 86 + int'($urandom_range(0, 9)) + scroll_m) % 768;
                hc = ($urandom_range(0, 1) == 1) ? PX[r] - 2 + int'($urandom_range(0, 52))
                                                 : int'($urandom_range(0, 1023));
                if (hc < 0) hc = 0;
            end else begin
                vc = int'($urandom_range(0, 767));
                hc = int'($urandom_range(0, 1023));
            end
            cycle(hc, vc, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 1) == 1, 12'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        cycle(70, (90 + scroll_m) % 768, 0, 0, 0, 12'h777);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_bits, address, platform_type, scroll_y} !== '0) begin
            fails++;
            $display("FAIL reset_mid: got out=%h addr=%h type=%h scroll=%h, expected all 0",
                     out_bits, address, platform_type, scroll_y);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        scroll_m = 0;
        prev_m = 0;
        q.delete();
        test_random(200);
    endtask

    initial begin
        test_reset();
        test_tile_hit();
        test_pool_hit();
        test_blanking();
        test_transparency();
        test_scroll();
        test_underflow();
        test_random(1500);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
